fb_write_scheduler: RTL and testbench

- Sequences and arbitrates the single write port of the double-buffered 320x180 RGB565 frame buffer.
- Each frame it runs three phases in order:
  - a background clear: ceiling colour on the upper half, floor colour on the lower half;
  - a draw phase, sharing the write port between the ray renderer and an overlay (HUD) writer;
  - a wait phase that holds until the video side finishes its frame, then flips the buffer select.
- Sits between the render producers and the frame buffer; drives its write address/data/enable and buffer-select.

---
 rtl/fb_write_scheduler_pkg.sv | 19 +
 rtl/fb_write_scheduler_arb.sv | 33 +++
 rtl/fb_write_scheduler.sv | 152 +++++++++++++++
 tb/tb_fb_write_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_write_scheduler_pkg.sv
// Shared types and default geometry for the frame-buffer write scheduler.
//   fb_state_t : frame phase (background clear, draw, wait for video swap)
//   rgb565_t   : one RGB565 pixel
//   FB_W/FB_H  : default logical screen size, FB_DEPTH pixels per buffer
package fb_pkg;

  localparam int FB_W     = 320;
  localparam int FB_H     = 180;
  localparam int FB_DEPTH = FB_W * FB_H;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    CLEAR,
    DRAW,
    WAIT_SWAP
  } fb_state_t;

endpackage

// File: rtl/fb_write_scheduler_arb.sv
// Two-requester round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   en       : arbitration enable; no grant while low
//   req[1:0] : requests (bit 0 wins ties after reset)
//   gnt[1:0] : one-hot combinational grant
// On a tie the requester that was not granted most recently wins; every
// grant, contested or not, moves the priority to the other requester.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1: requester 1 wins the next tie
  logic pri_1;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || !pri_1)) gnt = 2'b01;
      else if (req[1])                   gnt = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pri_1 <= 1'b0;
    else if (gnt[0]) pri_1 <= 1'b1;
    else if (gnt[1]) pri_1 <= 1'b0;
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Frame-buffer write-port scheduler for a double-buffered RGB565 display.
// Each frame: clear the back buffer (ceiling colour on upper half, floor on
// lower half), then share the write port between ray renderer and overlay,
// then wait for the video side to finish its frame and flip buffers.
//   pixel_clk_in, rst_in          : clock, asynchronous active-high reset
//   ray_valid/addr/data/ready     : ray write request handshake
//   ray_done_in                   : pulse, ray sweep complete (ends draw)
//   ovl_valid/addr/data/ready     : overlay write request handshake
//   video_last_pixel_in           : pulse, video finished reading a frame
//   fb_addr/data/we_out           : registered frame-buffer write port
//   buffer_sel_out                : 0 = write FB1/read FB2, 1 = the reverse
//   swap_out, frame_count_out     : flip pulse, completed swaps (wraps)
//   addr_err_out                  : sticky out-of-range request flag
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int      PIXEL_WIDTH   = 16,
  parameter int      SCREEN_WIDTH  = FB_W,
  parameter int      SCREEN_HEIGHT = FB_H,
  parameter rgb565_t CEIL_COLOR    = 16'h4208,
  parameter rgb565_t FLOOR_COLOR   = 16'h8410
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_in,
  input  logic                   ray_valid_in,
  input  logic [15:0]            ray_addr_in,
  input  logic [PIXEL_WIDTH-1:0] ray_data_in,
  output logic                   ray_ready_out,
  input  logic                   ray_done_in,
  input  logic                   ovl_valid_in,
  input  logic [15:0]            ovl_addr_in,
  input  logic [PIXEL_WIDTH-1:0] ovl_data_in,
  output logic                   ovl_ready_out,
  input  logic                   video_last_pixel_in,
  output logic [15:0]            fb_addr_out,
  output logic [PIXEL_WIDTH-1:0] fb_data_out,
  output logic                   fb_we_out,
  output logic                   buffer_sel_out,
  output logic                   swap_out,
  output logic [15:0]            frame_count_out,
  output logic                   addr_err_out
);

  localparam int          DEPTH     = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam logic [15:0] LAST_ADDR = 16'(DEPTH - 1);
  localparam logic [15:0] LAST_COL  = 16'(SCREEN_WIDTH - 1);
  localparam logic [15:0] HALF_ROW  = 16'(SCREEN_HEIGHT / 2);

  fb_state_t state, state_nxt;

  // Clear walks address, row and column together so the colour choice
  // needs only a row compare.
  logic [15:0] clr_addr, clr_row, clr_col;
  logic        clr_last;

  logic [1:0]             gnt;
  logic [15:0]            sel_addr;
  logic [PIXEL_WIDTH-1:0] sel_data;

  assign clr_last = (clr_addr == LAST_ADDR);

  rr_arbiter2 u_arb (
    .clk (pixel_clk_in),
    .rst (rst_in),
    .en  (state == DRAW),
    .req ({ovl_valid_in, ray_valid_in}),
    .gnt (gnt)
  );

  assign sel_addr = gnt[0] ? ray_addr_in : ovl_addr_in;
  assign sel_data = gnt[0] ? ray_data_in : ovl_data_in;

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) state <= CLEAR;
    else        state <= state_nxt;
  end

  // A video pulse outside WAIT_SWAP (including one coincident with
  // ray_done_in) is dropped; the video side simply repeats its frame.
  always_comb begin
    state_nxt     = state;
    ray_ready_out = gnt[0];
    ovl_ready_out = gnt[1];
    case (state)
      CLEAR:     if (clr_last)            state_nxt = DRAW;
      DRAW:      if (ray_done_in)         state_nxt = WAIT_SWAP;
      WAIT_SWAP: if (video_last_pixel_in) state_nxt = CLEAR;
      default:                            state_nxt = CLEAR;
    endcase
  end

  // Write-port register stage: everything below lands one cycle after the
  // clear step or accepted beat that produced it.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      clr_addr        <= '0;
      clr_row         <= '0;
      clr_col         <= '0;
      fb_addr_out     <= '0;
      fb_data_out     <= '0;
      fb_we_out       <= 1'b0;
      buffer_sel_out  <= 1'b0;
      swap_out        <= 1'b0;
      frame_count_out <= '0;
      addr_err_out    <= 1'b0;
    end else begin
      fb_we_out <= 1'b0;
      swap_out  <= 1'b0;
      case (state)
        CLEAR: begin
          fb_we_out   <= 1'b1;
          fb_addr_out <= clr_addr;
          fb_data_out <= (clr_row < HALF_ROW) ? CEIL_COLOR : FLOOR_COLOR;
          if (clr_last) begin
            clr_addr <= '0;
            clr_row  <= '0;
            clr_col  <= '0;
          end else begin
            clr_addr <= clr_addr + 16'd1;
            if (clr_col == LAST_COL) begin
              clr_col <= '0;
              clr_row <= clr_row + 16'd1;
            end else begin
              clr_col <= clr_col + 16'd1;
            end
          end
        end
        DRAW: begin
          // Out-of-range beats are consumed so the requester never stalls.
          if (gnt != 2'b00) begin
            if (sel_addr > LAST_ADDR) begin
              addr_err_out <= 1'b1;
            end else begin
              fb_we_out   <= 1'b1;
              fb_addr_out <= sel_addr;
              fb_data_out <= sel_data;
            end
          end
        end
        WAIT_SWAP: begin
          if (video_last_pixel_in) begin
            buffer_sel_out  <= ~buffer_sel_out;
            swap_out        <= 1'b1;
            frame_count_out <= frame_count_out + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
module tb_fb_write_scheduler;

  localparam int          W     = 8;
  localparam int          H     = 4;
  localparam int          DEPTH = W * H;
  localparam logic [15:0] CEIL  = 16'h4208;
  localparam logic [15:0] FLOOR = 16'h8410;

  logic        pixel_clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        ray_valid_in = 1'b0;
  logic [15:0] ray_addr_in = '0;
  logic [15:0] ray_data_in = '0;
  logic        ray_ready_out;
  logic        ray_done_in = 1'b0;
  logic        ovl_valid_in = 1'b0;
  logic [15:0] ovl_addr_in = '0;
  logic [15:0] ovl_data_in = '0;
  logic        ovl_ready_out;
  logic        video_last_pixel_in = 1'b0;
  logic [15:0] fb_addr_out;
  logic [15:0] fb_data_out;
  logic        fb_we_out;
  logic        buffer_sel_out;
  logic        swap_out;
  logic [15:0] frame_count_out;
  logic        addr_err_out;

  fb_write_scheduler #(
    .PIXEL_WIDTH   (16),
    .SCREEN_WIDTH  (W),
    .SCREEN_HEIGHT (H),
    .CEIL_COLOR    (CEIL),
    .FLOOR_COLOR   (FLOOR)
  ) dut (
    .pixel_clk_in        (pixel_clk_in),
    .rst_in              (rst_in),
    .ray_valid_in        (ray_valid_in),
    .ray_addr_in         (ray_addr_in),
    .ray_data_in         (ray_data_in),
    .ray_ready_out       (ray_ready_out),
    .ray_done_in         (ray_done_in),
    .ovl_valid_in        (ovl_valid_in),
    .ovl_addr_in         (ovl_addr_in),
    .ovl_data_in         (ovl_data_in),
    .ovl_ready_out       (ovl_ready_out),
    .video_last_pixel_in (video_last_pixel_in),
    .fb_addr_out         (fb_addr_out),
    .fb_data_out         (fb_data_out),
    .fb_we_out           (fb_we_out),
    .buffer_sel_out      (buffer_sel_out),
    .swap_out            (swap_out),
    .frame_count_out     (frame_count_out),
    .addr_err_out        (addr_err_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  typedef struct { logic [15:0] addr; logic [15:0] data; } req_t;
  typedef struct { logic [15:0] addr; logic [15:0] data; int due; } wr_t;

  req_t ray_q[$];
  req_t ovl_q[$];
  wr_t  exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit gate_en = 1'b0;

  // Reference model: phase 0 clear, 1 draw, 2 wait for video.
  int          m_phase = 0;
  int          m_clr_n = 0;
  int          m_last  = 1;   // 0: ray granted last, 1: overlay (ray favoured)
  bit          m_eray, m_eovl;
  logic        nxt_sel = 0, nxt_swap = 0, nxt_err = 0;
  logic [15:0] nxt_cnt = '0;
  logic        cur_sel = 0, cur_swap = 0, cur_err = 0;
  logic [15:0] cur_cnt = '0;
  wr_t         mon_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge pixel_clk_in) begin
    cyc++;
    if (rst_in) begin
      cur_sel = 0; cur_swap = 0; cur_err = 0; cur_cnt = '0;
    end else begin
      cur_sel = nxt_sel; cur_swap = nxt_swap; cur_err = nxt_err; cur_cnt = nxt_cnt;
    end
  end

  // Model step: decides what the DUT must do at the coming rising edge.
  always @(negedge pixel_clk_in) begin
    if (rst_in) begin
      m_phase = 0; m_clr_n = 0; m_last = 1;
      nxt_sel = 0; nxt_swap = 0; nxt_err = 0; nxt_cnt = '0;
      exp_q.delete();
    end else begin
      m_eray = 0; m_eovl = 0; nxt_swap = 0;
      if (m_phase == 1) begin
        if (ray_valid_in && ovl_valid_in) begin
          if (m_last == 0) m_eovl = 1; else m_eray = 1;
        end else begin
          m_eray = ray_valid_in;
          m_eovl = ovl_valid_in;
        end
      end
      chk("ray_ready", {31'd0, ray_ready_out}, {31'd0, m_eray});
      chk("ovl_ready", {31'd0, ovl_ready_out}, {31'd0, m_eovl});
      case (m_phase)
        0: begin
          exp_q.push_back('{16'(m_clr_n), ((m_clr_n / W) < (H / 2)) ? CEIL : FLOOR, cyc + 1});
          m_clr_n++;
          if (m_clr_n == DEPTH) begin m_clr_n = 0; m_phase = 1; end
        end
        1: begin
          if (m_eray) begin
            m_last = 0;
            if (int'(ray_addr_in) >= DEPTH) nxt_err = 1;
            else exp_q.push_back('{ray_addr_in, ray_data_in, cyc + 1});
          end else if (m_eovl) begin
            m_last = 1;
            if (int'(ovl_addr_in) >= DEPTH) nxt_err = 1;
            else exp_q.push_back('{ovl_addr_in, ovl_data_in, cyc + 1});
          end
          if (ray_done_in) m_phase = 2;
        end
        default: begin
          if (video_last_pixel_in) begin
            nxt_sel = ~nxt_sel; nxt_cnt = nxt_cnt + 16'd1; nxt_swap = 1;
            m_phase = 0;
          end
        end
      endcase
    end
  end

  // Monitor: compares the write port and status outputs each cycle.
  always @(negedge pixel_clk_in) begin
    if (!rst_in) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        mon_w = exp_q.pop_front();
        chk("fb_we", {31'd0, fb_we_out}, 32'd1);
        chk("fb_addr", {16'd0, fb_addr_out}, {16'd0, mon_w.addr});
        chk("fb_data", {16'd0, fb_data_out}, {16'd0, mon_w.data});
      end else begin
        chk("fb_we_idle", {31'd0, fb_we_out}, 32'd0);
      end
      chk("buffer_sel", {31'd0, buffer_sel_out}, {31'd0, cur_sel});
      chk("swap", {31'd0, swap_out}, {31'd0, cur_swap});
      chk("frame_count", {16'd0, frame_count_out}, {16'd0, cur_cnt});
      chk("addr_err", {31'd0, addr_err_out}, {31'd0, cur_err});
    end
  end

  task automatic drive();
    if (rst_in) begin
      ray_valid_in = 0; ovl_valid_in = 0;
      return;
    end
    ray_valid_in = 0; ovl_valid_in = 0;
    if (ray_q.size() > 0) begin
      ray_addr_in = ray_q[0].addr; ray_data_in = ray_q[0].data;
      if (!gate_en || $urandom_range(0, 3) != 0) ray_valid_in = 1;
    end
    if (ovl_q.size() > 0) begin
      ovl_addr_in = ovl_q[0].addr; ovl_data_in = ovl_q[0].data;
      if (!gate_en || $urandom_range(0, 3) != 0) ovl_valid_in = 1;
    end
  endtask

  task automatic step();
    logic rr, orr;
    @(negedge pixel_clk_in);
    rr = ray_ready_out; orr = ovl_ready_out;
    @(posedge pixel_clk_in); #1;
    if (rr && ray_q.size() > 0) void'(ray_q.pop_front());
    if (orr && ovl_q.size() > 0) void'(ovl_q.pop_front());
    ray_done_in = 0;
    video_last_pixel_in = 0;
    drive();
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) begin
      ray_q.push_back('{16'($urandom_range(0, DEPTH - 1)), 16'($urandom)});
      ovl_q.push_back('{16'($urandom_range(0, DEPTH - 1)), 16'($urandom)});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_in = 1;
    repeat (3) @(posedge pixel_clk_in);
    @(negedge pixel_clk_in);
    chk("rst_we", {31'd0, fb_we_out}, 32'd0);
    chk("rst_addr", {16'd0, fb_addr_out}, 32'd0);
    chk("rst_sel", {31'd0, buffer_sel_out}, 32'd0);
    chk("rst_count", {16'd0, frame_count_out}, 32'd0);
    chk("rst_ready", {30'd0, ray_ready_out, ovl_ready_out}, 32'd0);

    // Frame 1: both requesters contend from the start of draw.
    ray_q.push_back('{16'd1, 16'h1111});
    ray_q.push_back('{16'd2, 16'h2222});
    ovl_q.push_back('{16'd9, 16'h9999});
    ovl_q.push_back('{16'd10, 16'hAAAA});
    @(posedge pixel_clk_in); #1;
    rst_in = 0;
    drive();
    repeat (40) step();
    ray_q.push_back('{16'd40, 16'hBEEF});
    drive();
    repeat (3) step();
    gate_en = 1;
    push_random(8);
    repeat (20) step();
    gate_en = 0;
    ray_q.push_back('{16'($urandom_range(0, DEPTH - 1)), 16'($urandom)});
    drive();
    ray_done_in = 1;
    step();
    repeat (9) step();
    video_last_pixel_in = 1;
    step();

    // Frame 2: early video pulse during draw must not flip.
    repeat (34) step();
    video_last_pixel_in = 1;
    step();
    gate_en = 1;
    push_random(4);
    repeat (10) step();
    ray_done_in = 1;
    step();
    repeat (5) step();
    video_last_pixel_in = 1;
    step();

    // Frame 3: coincident done and video pulse; only the later pulse flips.
    repeat (34) step();
    ray_done_in = 1;
    video_last_pixel_in = 1;
    step();
    repeat (4) step();
    video_last_pixel_in = 1;
    step();
    chk("count_after_3", {16'd0, frame_count_out}, 32'd3);

    // Frame 4: asynchronous reset in the middle of clear.
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (fb_we_out && fb_addr_out == 16'd12) found = 1;
    end
    chk("reach_addr12", {31'd0, found}, 32'd1);
    chk("sel_before_rst", {31'd0, buffer_sel_out}, 32'd1);
    #2;
    rst_in = 1;
    #1;
    chk("async_we", {31'd0, fb_we_out}, 32'd0);
    chk("async_addr", {16'd0, fb_addr_out}, 32'd0);
    chk("async_data", {16'd0, fb_data_out}, 32'd0);
    chk("async_sel", {31'd0, buffer_sel_out}, 32'd0);
    chk("async_count", {16'd0, frame_count_out}, 32'd0);
    chk("async_err", {31'd0, addr_err_out}, 32'd0);
    ray_q.delete();
    ovl_q.delete();
    gate_en = 0;
    ray_done_in = 0;
    video_last_pixel_in = 0;
    drive();
    repeat (2) @(posedge pixel_clk_in);
    #1;
    rst_in = 0;
    drive();
    repeat (36) step();
    chk("sel_after_rst", {31'd0, buffer_sel_out}, 32'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
